// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: host request/response and RAM port bundle of vram_arbiter.
interface vram_arbiter_if #(parameter int ADDR_W = 15, parameter int DATA_W = 3);
  logic              host_req, host_we, host_gnt, host_done, host_err;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] host_addr, mem_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata, mem_wdata, mem_rdata;
  modport slave (
    input  host_req, host_we, host_addr, host_wdata, mem_rdata,
    output host_gnt, host_done, host_rdata, host_err, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  host_gnt, host_done, host_rdata, host_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video RAM between VGA scan-out (priority) and a host port.
// Define VRAM_ARB_BOUNDS_CHK_EN to reject host addresses outside the FB_W*FB_H framebuffer.
module vram_arbiter #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int SCALE_SH = 2,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              utick_i,
  input  logic              video_on_i,
  input  logic [9:0]        pixel_x_i,
  input  logic [9:0]        pixel_y_i,
  output logic [DATA_W-1:0] disp_rgb_o,
  vram_arbiter_if.slave     bus
);
`ifdef VRAM_ARB_BOUNDS_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, DRD, DCAP, HACC, HCAP} state_t;
  state_t            state_q, state_d;
  logic              pend_q, pend_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d, disp_addr;
  logic [DATA_W-1:0] rgb_q, rgb_d, rdata_q, rdata_d;
  logic              vtick, pend_w, oob, host_ok;
  assign vtick     = utick_i & video_on_i;
  assign pend_w    = pend_q | vtick;
  assign disp_addr = ADDR_W'((32'(pixel_y_i) >> SCALE_SH) * FB_W + (32'(pixel_x_i) >> SCALE_SH));
  assign oob       = CHK && (32'(bus.host_addr) >= 32'(FB_W * FB_H));
  assign host_ok   = (state_q == HACC) && !oob;
  assign bus.mem_en     = (state_q == DRD) || host_ok;
  assign bus.mem_we     = host_ok && bus.host_we;
  assign bus.mem_addr   = state_q == DRD ? daddr_q : host_ok ? bus.host_addr : '0;
  assign bus.mem_wdata  = (host_ok && bus.host_we) ? bus.host_wdata : '0;
  assign bus.host_gnt   = state_q == HACC;
  assign bus.host_done  = state_q == HCAP;
  assign bus.host_err   = CHK && (state_q == HCAP) && err_q;
  // Read data is forwarded combinationally so it is valid in the done cycle, then held.
  assign bus.host_rdata = (state_q == HCAP && !we_q && !err_q) ? bus.mem_rdata : rdata_q;
  assign disp_rgb_o     = rgb_q;
  always_comb begin
    state_d = state_q;
    pend_d  = vtick | (pend_q & (state_q != DRD));
    daddr_d = vtick ? disp_addr : daddr_q;
    we_d    = state_q == HACC ? bus.host_we : we_q;
    err_d   = state_q == HACC ? oob : err_q;
    rgb_d   = state_q == DCAP ? bus.mem_rdata : (utick_i & ~video_on_i) ? '0 : rgb_q;
    rdata_d = bus.host_rdata;
    case (state_q)
      IDLE:    state_d = pend_w ? DRD : bus.host_req ? HACC : IDLE;
      DRD:     state_d = DCAP;
      DCAP:    state_d = (bus.host_req && !pend_w) ? HACC : IDLE;
      HACC:    state_d = HCAP;
      HCAP:    state_d = pend_w ? DRD : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      daddr_q <= '0;
      rgb_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      err_q   <= err_d;
      daddr_q <= daddr_d;
      rgb_q   <= rgb_d;
      rdata_q <= rdata_d;
    end
  end
endmodule
